// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, bus widths and the latched request.
package dmem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned WIDX_W     = ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic [WIDX_W-1:0]     word_idx;
      logic [DATA_W-1:0]     wdata;
      logic [WORD_BYTES-1:0] be;
      logic                  is_write;
      logic                  err_flag;
   } dmem_req_t;

   // True when no address bit above the RAM's word index is set.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int unsigned idx_w);
      return (addr >> (idx_w + 2)) == '0;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte synchronous write enables and a registered, enabled read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic                        we_i,
   input  logic [WORD_BYTES-1:0]       be_i,
   input  logic [DATA_W-1:0]           wdata_i,
   input  logic                        re_i,
   input  logic                        rzero_i,
   output logic [DATA_W-1:0]           rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read register only loads when enabled, so it holds across writes and idle cycles.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rzero_i ? '0 : mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the CPU data port.
// Define DMEM_RANGE_CHECK_EN to add data_mem_err and out-of-range / read+write conflict detection.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_mem_address,
   input  logic        data_mem_read,
   input  logic        data_mem_write,
   input  logic [31:0] data_mem_wdata,
   input  logic [3:0]  data_mem_byte_enable,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp
`ifdef DMEM_RANGE_CHECK_EN
   ,
   output logic        data_mem_err
`endif
);

   localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W        = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam bit          SINGLE_CYCLE = (LATENCY == 1);

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dmem_req_t        req_q, req_d;
   logic             resp_q, resp_d;
   logic             err_d;

   logic             rd_en_c;
   logic             wr_en_c;
   logic [IDX_W-1:0] ram_addr_c;
   logic             unused_bits;

   // Next-state: latch in IDLE, count down in BUSY, single response cycle in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      resp_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (data_mem_read || data_mem_write) begin
               req_d.word_idx = data_mem_address[ADDR_W-1:2];
               req_d.wdata    = data_mem_wdata;
               req_d.be       = data_mem_byte_enable;
               req_d.is_write = data_mem_write;
`ifdef DMEM_RANGE_CHECK_EN
               req_d.err_flag = !addr_in_range(data_mem_address, IDX_W) ||
                                (data_mem_read && data_mem_write);
`else
               req_d.err_flag = 1'b0;
`endif
               cnt_d = CNT_INIT;
               if (SINGLE_CYCLE) begin
                  state_d = RESP;
                  resp_d  = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               resp_d  = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      err_d = resp_d & req_d.err_flag;
   end

   // Read on entry to RESP; write at the end of RESP so a reset in flight drops it.
   assign rd_en_c    = resp_d & ~req_d.is_write;
   assign wr_en_c    = (state_q == RESP) & req_q.is_write & ~req_q.err_flag;
   assign ram_addr_c = req_d.word_idx[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         resp_q  <= resp_d;
      end
   end

`ifdef DMEM_RANGE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign data_mem_err = err_q;
`else
   logic unused_err;
   assign unused_err = err_d;
`endif

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk),
      .rst_n_i (rst),
      .addr_i  (ram_addr_c),
      .we_i    (wr_en_c),
      .be_i    (req_q.be),
      .wdata_i (req_q.wdata),
      .re_i    (rd_en_c),
      .rzero_i (req_d.err_flag),
      .rdata_o (data_mem_rdata)
   );

   assign data_mem_resp = resp_q;

   // Byte offset and aliased upper index bits are intentionally not used for addressing.
   assign unused_bits = ^data_mem_address[1:0] ^ (|(req_q.word_idx >> IDX_W));

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic against a behavioural model.
module tb_data_mem_responder;

   localparam int          LAT   = 2;
   localparam int          LAT3  = 3;
   localparam int unsigned DEPTH = 1024;
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data_mem_address = '0;
   logic        data_mem_read = 1'b0;
   logic        data_mem_write = 1'b0;
   logic [31:0] data_mem_wdata = '0;
   logic [3:0]  data_mem_byte_enable = '0;
   logic [31:0] data_mem_rdata, rdata3;
   logic        data_mem_resp, resp3;
   logic        data_mem_err, err3;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .data_mem_address(data_mem_address), .data_mem_read(data_mem_read),
      .data_mem_write(data_mem_write), .data_mem_wdata(data_mem_wdata),
      .data_mem_byte_enable(data_mem_byte_enable),
      .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp)
`ifdef DMEM_RANGE_CHECK_EN
      , .data_mem_err(data_mem_err)
`endif
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT3)) u_dut3 (
      .clk(clk), .rst(rst),
      .data_mem_address(data_mem_address), .data_mem_read(data_mem_read),
      .data_mem_write(data_mem_write), .data_mem_wdata(data_mem_wdata),
      .data_mem_byte_enable(data_mem_byte_enable),
      .data_mem_rdata(rdata3), .data_mem_resp(resp3)
`ifdef DMEM_RANGE_CHECK_EN
      , .data_mem_err(err3)
`endif
   );

`ifndef DMEM_RANGE_CHECK_EN
   assign data_mem_err = 1'b0;
   assign err3         = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: word-addressed memory plus "edges since accept" bookkeeping.
   logic [31:0] mdl_mem [DEPTH];
   int          since = -1;
   int unsigned m_idx;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_wr, m_err;
   logic        exp_resp = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            since     = -1;
            exp_resp  = 1'b0;
            exp_rdata = '0;
            exp_err   = 1'b0;
         end else begin
            if (since < 0) begin
               if (data_mem_read || data_mem_write) begin
                  since   = 0;
                  m_idx   = (data_mem_address >> 2) % DEPTH;
                  m_wdata = data_mem_wdata;
                  m_be    = data_mem_byte_enable;
                  m_wr    = data_mem_write;
                  m_err   = RANGE_EN && (((data_mem_address >> 2) >= DEPTH) ||
                                         (data_mem_read && data_mem_write));
               end
            end else begin
               since++;
               if (since == LAT) begin
                  if (m_wr && !m_err) begin
                     for (int b = 0; b < 4; b++) begin
                        if (m_be[b]) mdl_mem[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
                     end
                  end
                  since = -1;
               end
            end
            exp_resp = (since == LAT - 1);
            exp_err  = exp_resp && m_err;
            if (exp_resp && !m_wr) exp_rdata = m_err ? 32'h0 : mdl_mem[m_idx];
         end
         @(negedge clk);
         check("resp", {31'b0, data_mem_resp}, {31'b0, exp_resp});
         check("rdata", data_mem_rdata, exp_rdata);
         if (RANGE_EN) check("err", {31'b0, data_mem_err}, {31'b0, exp_err});
      end
   end

   // Issue one request, hold it until resp, then release.
   task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata_s, output logic err_s);
      int lat;
      @(negedge clk);
      #1;
      data_mem_read        = rd;
      data_mem_write       = wr;
      data_mem_address     = addr;
      data_mem_wdata       = wdata;
      data_mem_byte_enable = be;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (data_mem_resp === 1'b1) begin
            lat = n;
            break;
         end
      end
      rdata_s = data_mem_rdata;
      err_s   = data_mem_err;
      #1;
      data_mem_read  = 1'b0;
      data_mem_write = 1'b0;
      check("op_latency", 32'(lat), 32'(LAT));
   endtask

   logic [31:0] rd_v;
   logic        er_v;
   logic        r2 [1:10];
   logic        r3 [1:10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_resp", {31'b0, data_mem_resp}, 32'h0);
      check("reset_rdata", data_mem_rdata, 32'h0);
      if (RANGE_EN) check("reset_err", {31'b0, data_mem_err}, 32'h0);
      #1 rst = 1'b1;

      // Known background contents for the words the bench touches.
      for (int i = 0; i < 16; i++) begin
         do_op(1'b0, 1'b1, 32'(i * 4), {16'hCAFE, 16'(i)}, 4'hF, rd_v, er_v);
      end

      do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd_v, er_v);
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd_v, er_v);
      check("basic_read", rd_v, 32'hDEADBEEF);

      do_op(1'b0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, rd_v, er_v);
      do_op(1'b1, 1'b0, 32'h12, 32'h0, 4'h0, rd_v, er_v);
      check("byte_lane_read", rd_v, 32'hDEAABEEF);

      repeat (6) @(negedge clk);
      #1;
      data_mem_read    = 1'b1;
      data_mem_address = 32'h10;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         r2[i] = data_mem_resp;
         r3[i] = resp3;
      end
      #1 data_mem_read = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         check("held_resp_lat3", {31'b0, r3[i]}, {31'b0, (i == 3 || i == 7)});
         check("held_resp_lat2", {31'b0, r2[i]}, {31'b0, (i >= LAT && ((i - LAT) % (LAT + 1)) == 0)});
         if (i > 1) check("held_no_back_to_back", {31'b0, r3[i-1] & r3[i]}, 32'h0);
      end
      repeat (8) @(negedge clk);

      #1;
      data_mem_write       = 1'b1;
      data_mem_address     = 32'h20;
      data_mem_wdata       = 32'h12345678;
      data_mem_byte_enable = 4'hF;
      @(negedge clk);
      #1;
      rst            = 1'b0;
      data_mem_write = 1'b0;
      @(negedge clk);
      check("rst_midop_resp", {31'b0, data_mem_resp}, 32'h0);
      check("rst_midop_rdata", data_mem_rdata, 32'h0);
      @(negedge clk);
      check("rst_midop_resp_hold", {31'b0, data_mem_resp | resp3}, 32'h0);
      #1 rst = 1'b1;
      do_op(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd_v, er_v);
      check("rst_midop_ram_kept", rd_v, 32'hCAFE0008);

      do_op(1'b1, 1'b1, 32'h30, 32'h55, 4'b0001, rd_v, er_v);
      if (RANGE_EN) check("rw_conflict_err", {31'b0, er_v}, 32'h1);
      do_op(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd_v, er_v);
      check("rw_conflict_read", rd_v, RANGE_EN ? 32'hCAFE000C : 32'hCAFE0055);

      do_op(1'b1, 1'b0, 32'h00001000, 32'h0, 4'h0, rd_v, er_v);
      check("range_read", rd_v, RANGE_EN ? 32'h0 : 32'hCAFE0000);
      if (RANGE_EN) check("range_err", {31'b0, er_v}, 32'h1);

      do_op(1'b0, 1'b1, 32'h3C, 32'hFFFFFFFF, 4'h0, rd_v, er_v);
      do_op(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, rd_v, er_v);
      check("be_zero_no_change", rd_v, 32'hCAFE000F);

      for (int k = 0; k < 300; k++) begin
         int unsigned kind;
         logic [31:0] addr;
         kind = $urandom_range(0, 9);
         addr = ($urandom & 32'h3C) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 255)) << 12);
         do_op(kind <= 3 || kind == 9, kind >= 4, addr, $urandom, 4'($urandom_range(0, 15)), rd_v, er_v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-cache port.
- Accepts word-aligned read/write requests (address, wdata, 4-bit byte enable) from the pipeline's MEM stage.
- Services them from an internal byte-lane RAM after a fixed latency and returns a one-cycle resp pulse with read data.
- Used as the data memory model/backing store in CPU-level simulation and as the stand-in for the cache during pipeline bring-up.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from request acceptance to resp; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_mem_address  input  32  byte address; bits [1:0] ignored.
- data_mem_read  input  1  read request; held by the initiator until resp.
- data_mem_write  input  1  write request; held by the initiator until resp.
- data_mem_wdata  input  32  write data, lane-positioned.
- data_mem_byte_enable  input  4  write lane mask; bit i enables byte i (bits [8i+7:8i]).
- data_mem_rdata  output  32  read data; valid in the resp cycle of a read.
- data_mem_resp  output  1  one-cycle completion pulse.
- data_mem_err  output  1  only present when DMEM_RANGE_CHECK_EN is defined.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, data_mem_resp=0, data_mem_rdata=0, data_mem_err=0, latency counter=0, latched request cleared. RAM contents are not reset.
- Reset mid-operation: the transaction is aborted and a pending write is dropped (RAM unchanged). No resp is issued.
- States:
  - IDLE: if read|write is sampled high at a rising edge, latch address word index, wdata, byte_enable and op; counter<=LATENCY-1; go to BUSY if LATENCY>1, else RESP.
  - BUSY: decrement counter; at counter==1, go to RESP. Inputs are ignored while in BUSY.
  - RESP: data_mem_resp=1 for exactly this cycle.
    - Write: RAM updated with the enabled lanes at the end of this cycle.
    - Read: data_mem_rdata driven with the RAM word of the latched index.
    - Next state: always IDLE. No request is accepted in RESP, so an initiator still holding the same request is not serviced twice.
- Timing: request accepted at edge t; resp is high during cycle t+LATENCY. Maximum throughput is one transaction per LATENCY+1 cycles.
- data_mem_rdata is registered. It updates only on a read's RESP and holds its value otherwise, including across writes.
- Read and write both high: treated as a write; the read is dropped.
- Write with byte_enable=0: no RAM change, resp still issued.
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored (aliasing) unless range check is enabled.
- Input values changing during BUSY have no effect, because the request is latched in IDLE.

Optional Feature:
- DMEM_RANGE_CHECK_EN defined:
  - data_mem_err port exists.
  - In RESP, err=1 if the latched address[31:log2(DEPTH_WORDS)+2] is nonzero, or if read and write were both high at acceptance.
  - On an erroring write, the RAM is not modified.
  - On an erroring read, rdata is forced to 32'h0.
  - resp is still issued.
- Not defined: port absent, aliasing applies, no error detection.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {IDLE, BUSY, RESP}.
  - WORD_BYTES=4.
  - Request struct {word index, wdata, be, is_write, err_flag}.
- One sub-module, dmem_array: single-port RAM with synchronous 4-lane byte write enable and synchronous read, instantiated with DEPTH_WORDS.

Test Plan:
- Basic write/read:
  - Stimulus: LATENCY=2; write addr 0x10, wdata 0xDEADBEEF, be 4'b1111; after resp, read addr 0x10.
  - Response: resp exactly 2 cycles after each accept; rdata=0xDEADBEEF.
- Byte lanes:
  - Stimulus: from 0xDEADBEEF at 0x10, write wdata 0x00AA0000 with be 4'b0100, then read addr 0x12.
  - Response: rdata=0xDEAABEEF, since bits [1:0] are ignored.
- Held request:
  - Stimulus: read held high for 10 cycles at LATENCY=3.
  - Response: resp pulses at cycles 3 and 7 (relative to the first accept), one cycle wide. Never high in consecutive cycles.
- Reset mid-op:
  - Stimulus: write 0x12345678 to 0x20, assert rst in BUSY, release, then read 0x20.
  - Response: no resp during reset; rdata equals the prior contents, not 0x12345678.
- Simultaneous read and write:
  - Stimulus: read=write=1, addr 0x30, wdata 0x55, be 4'b0001.
  - Response: write performed, a later read returns 0x55 in byte 0. With DMEM_RANGE_CHECK_EN: err=1 and RAM unchanged.
- Range check:
  - Stimulus: DMEM_RANGE_CHECK_EN defined, DEPTH_WORDS=1024; read addr 0x00001000.
  - Response: resp=1, err=1, rdata=0. Without the macro: aliases to word 0.
